// File: rtl/rule90_ctrl.sv
// rule90_ctrl: button sync/debounce/press-edge front end, play/pause FSM and step tick for the rule-90 core.
// Defining RULE90_CTRL_SINGLE_STEP_EN adds a btn_step input that single-steps the core while paused.
module rule90_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 25000000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_load,
    input  logic       btn_start_stop,
`ifdef RULE90_CTRL_SINGLE_STEP_EN
    input  logic       btn_step,
`endif
    input  logic [1:0] speed,
    output logic       load_pulse,
    output logic       running,
    output logic       step_en
);
`ifdef RULE90_CTRL_SINGLE_STEP_EN
    localparam int NB = 3;
    logic [NB-1:0] btn;
    assign btn = {btn_step, btn_start_stop, btn_load};
`else
    localparam int NB = 2;
    logic [NB-1:0] btn;
    assign btn = {btn_start_stop, btn_load};
`endif
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TDIV    = CNT_W'(TICK_DIV);

    typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_t;

    logic [NB-1:0]    press;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] tc, limit;

    for (genvar i = 0; i < NB; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] s;
        logic [CNT_W-1:0]       c;
        logic                   d, dq;
        always_ff @(posedge clk) begin
            if (rst) begin
                s  <= '0;
                c  <= '0;
                d  <= 1'b0;
                dq <= 1'b0;
            end else begin
                s  <= {s[SYNC_STAGES-2:0], btn[i]};
                dq <= d;
                if (s[SYNC_STAGES-1] == d) c <= '0;
                else if (c == DB_LAST) begin
                    d <= s[SYNC_STAGES-1];
                    c <= '0;
                end else c <= c + CNT_W'(1);
            end
        end
        assign press[i] = d & ~dq;
    end

    // press[0] = load, press[1] = start/stop, press[2] = step; load beats everything
    always_comb begin
        limit     = (TDIV >> speed) - CNT_W'(1);
        state_nxt = press[0] ? PAUSED : press[1] ? (state == RUNNING ? PAUSED : RUNNING) : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PAUSED;
            tc         <= '0;
            load_pulse <= 1'b0;
            step_en    <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_pulse <= press[0];
            if (state == RUNNING && state_nxt == RUNNING) begin
                tc      <= tc >= limit ? '0 : tc + CNT_W'(1);
                step_en <= tc >= limit;
            end else begin
                tc      <= '0;
`ifdef RULE90_CTRL_SINGLE_STEP_EN
                step_en <= press[2] && state == PAUSED && !press[0];
`else
                step_en <= 1'b0;
`endif
            end
        end
    end

    assign running = state == RUNNING;
endmodule

// File: tb/tb_rule90_ctrl.sv
// tb_rule90_ctrl: randomized and directed bench for rule90_ctrl against a window-based reference model.
module tb_rule90_ctrl;
    localparam int SYNC = 2, DEB = 4, TDIV = 8, L = SYNC + DEB + 1, HN = 8192;

    logic       clk = 0, rst = 1, btn_load = 0, btn_start_stop = 0;
    logic [1:0] speed = 0;
    logic       load_pulse, running, step_en;
`ifdef RULE90_CTRL_SINGLE_STEP_EN
    logic       btn_step = 0;
`endif

    int       checks = 0, errors = 0, cyc = 0;
    bit       raw_h [3][HN];
    bit       cmd [3][HN];
    bit       stable [3];
    bit       m_run;
    int       since;
    logic [2:0] m_exp;

    rule90_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .btn_load(btn_load),
        .btn_start_stop(btn_start_stop),
`ifdef RULE90_CTRL_SINGLE_STEP_EN
        .btn_step(btn_step),
`endif
        .speed(speed),
        .load_pulse(load_pulse),
        .running(running),
        .step_en(step_en)
    );

    always #5 clk = ~clk;

    // Advance one clock edge; the model predicts {load_pulse, running, step_en} after it.
    // A press is accepted when the raw level has been seen high for DEB consecutive edges
    // while the stable level is low; its command appears SYNC+1 edges after that window.
    task automatic cycle();
        bit lp, ss, st, nrun, same;
        int p;
        cyc++;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                raw_h[b][cyc] = 0;
                stable[b] = 0;
                for (int k = cyc; k <= cyc + L; k++) cmd[b][k] = 0;
            end
            m_run = 0;
            since = 0;
            m_exp = 3'b000;
        end else begin
            raw_h[0][cyc] = btn_load;
            raw_h[1][cyc] = btn_start_stop;
`ifdef RULE90_CTRL_SINGLE_STEP_EN
            raw_h[2][cyc] = btn_step;
`else
            raw_h[2][cyc] = 0;
`endif
            for (int b = 0; b < 3; b++) begin
                if (cyc >= DEB) begin
                    same = 1;
                    for (int k = 1; k < DEB; k++) if (raw_h[b][cyc-k] != raw_h[b][cyc]) same = 0;
                    if (same && raw_h[b][cyc] != stable[b]) begin
                        stable[b] = raw_h[b][cyc];
                        if (stable[b]) cmd[b][cyc+SYNC+1] = 1;
                    end
                end
            end
            lp = cmd[0][cyc];
            ss = cmd[1][cyc];
            st = cmd[2][cyc];
            nrun = lp ? 0 : ss ? !m_run : m_run;
            p = TDIV >> speed;
            m_exp[0] = 0;
            if (m_run && nrun) begin
                since++;
                if (since >= p) begin
                    m_exp[0] = 1;
                    since = 0;
                end
            end else begin
                since = 0;
                m_exp[0] = st && !m_run && !lp;
            end
            m_run = nrun;
            m_exp[1] = nrun;
            m_exp[2] = lp;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first = 0;
        rst = 1; btn_load = 1; btn_start_stop = 1; speed = 0;
`ifdef RULE90_CTRL_SINGLE_STEP_EN
        btn_step = 1;
`endif
        repeat (2) begin
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=000", cyc, {load_pulse, running, step_en});
            end
        end
        rst = 0; btn_start_stop = 0;
`ifdef RULE90_CTRL_SINGLE_STEP_EN
        btn_step = 0;
`endif
        for (int n = 1; n <= 22; n++) begin
            if (n == 13) btn_load = 0;
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (load_pulse && first == 0) first = n;
        end
        checks++;
        if (first != L) begin
            errors++;
            $display("FAIL reset_first_load got=%0d exp=%0d", first, L);
        end
    endtask

    task automatic test_bounce();
        int cnt = 0, at = 0;
        bit pat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        for (int n = 0; n < 8 + 12 + 10; n++) begin
            btn_load = n < 8 ? pat[n] : n < 20;
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (load_pulse) begin
                cnt++;
                at = n - 7;
            end
        end
        checks++;
        if (cnt != 1 || at != L) begin
            errors++;
            $display("FAIL bounce_pulse got count=%0d edge=%0d exp count=1 edge=%0d", cnt, at, L);
        end
    endtask

    task automatic test_play_pause();
        int rise = 0, ns = 0, fall = 0, late = 0;
        int steps [3] = '{0, 0, 0};
        int want [3] = '{8, 16, 24};
        speed = 0;
        btn_start_stop = 1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 7) btn_start_stop = 0;
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL play_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (running && rise == 0) rise = n;
            if (step_en && ns < 3) begin
                steps[ns] = n - rise;
                ns++;
            end
        end
        checks++;
        if (rise != L) begin
            errors++;
            $display("FAIL play_rise got=%0d exp=%0d", rise, L);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (steps[k] != want[k]) begin
                errors++;
                $display("FAIL play_tick%0d got=%0d exp=%0d", k, steps[k], want[k]);
            end
        end
        btn_start_stop = 1;
        for (int n = 1; n <= 30; n++) begin
            if (n == 7) btn_start_stop = 0;
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL pause_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (!running && fall == 0) fall = n;
            if (fall != 0 && step_en) late++;
        end
        checks++;
        if (fall != L || late != 0) begin
            errors++;
            $display("FAIL pause_stop got fall=%0d late_steps=%0d exp fall=%0d late_steps=0", fall, late, L);
        end
    endtask

    task automatic test_speed_change();
        int rise = 0, ns = 0;
        int steps [3] = '{0, 0, 0};
        int want [3] = '{7, 9, 11};
        speed = 0;
        btn_start_stop = 1;
        for (int n = 1; n <= 30; n++) begin
            if (n == 7) btn_start_stop = 0;
            if (rise != 0 && n == rise + 7) speed = 2;
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL speed_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (running && rise == 0) rise = n;
            if (step_en && ns < 3) begin
                steps[ns] = n - rise;
                ns++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (steps[k] != want[k]) begin
                errors++;
                $display("FAIL speed_tick%0d got=%0d exp=%0d", k, steps[k], want[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int at = 0, cnt = 0;
        logic [1:0] at_state = 2'b11;
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL simul_precond running got=%b exp=1", running);
        end
        speed = 0;
        btn_load = 1;
        btn_start_stop = 1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 7) begin
                btn_load = 0;
                btn_start_stop = 0;
            end
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL simul_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (load_pulse) begin
                cnt++;
                at = n;
                at_state = {running, step_en};
            end
        end
        checks++;
        if (cnt != 1 || at != L || at_state !== 2'b00) begin
            errors++;
            $display("FAIL simul_load_wins got count=%0d edge=%0d run_step=%b exp count=1 edge=%0d run_step=00",
                     cnt, at, at_state, L);
        end
    endtask

`ifdef RULE90_CTRL_SINGLE_STEP_EN
    task automatic test_single_step();
        int cnt = 0, at = 0;
        btn_step = 1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 7) btn_step = 0;
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL step_paused_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (step_en) begin
                cnt++;
                at = n;
            end
        end
        checks++;
        if (cnt != 1 || at != L) begin
            errors++;
            $display("FAIL step_paused got count=%0d edge=%0d exp count=1 edge=%0d", cnt, at, L);
        end
        cnt = 0;
        speed = 0;
        btn_start_stop = 1;
        for (int n = 1; n <= 12; n++) begin
            if (n == 7) btn_start_stop = 0;
            cycle();
        end
        btn_step = 1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 7) btn_step = 0;
            cycle();
            checks++;
            if ({load_pulse, running, step_en} !== m_exp) begin
                errors++;
                $display("FAIL step_running_model cyc=%0d got=%b exp=%b", cyc, {load_pulse, running, step_en}, m_exp);
            end
            if (step_en) cnt++;
        end
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL step_running_ignored got steps=%0d exp=3", cnt);
        end
        btn_start_stop = 1;
        for (int n = 1; n <= 14; n++) begin
            if (n == 7) btn_start_stop = 0;
            cycle();
        end
    endtask
`endif

    task automatic test_random();
        int sel, hi, lo;
        bit glitch, both;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            glitch = $urandom_range(0, 3) == 0;
            both = $urandom_range(0, 7) == 0;
            hi = glitch ? $urandom_range(1, DEB - 1) : $urandom_range(DEB, DEB + 4);
            lo = $urandom_range(6, 12);
            if ($urandom_range(0, 2) == 0) speed = 2'($urandom_range(0, 3));
            for (int n = 0; n < hi + lo; n++) begin
                btn_load = n < hi && (sel == 0 || both);
                btn_start_stop = n < hi && ((sel >= 1 && sel <= 6) || both);
`ifdef RULE90_CTRL_SINGLE_STEP_EN
                btn_step = n < hi && sel >= 7;
`else
                if (sel >= 7) btn_start_stop = n < hi;
`endif
                cycle();
                checks++;
                if ({load_pulse, running, step_en} !== m_exp) begin
                    errors++;
                    $display("FAIL random_model it=%0d cyc=%0d got=%b exp=%b", it, cyc,
                             {load_pulse, running, step_en}, m_exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_play_pause();
        test_speed_change();
        test_simultaneous();
`ifdef RULE90_CTRL_SINGLE_STEP_EN
        test_single_step();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
